// File: rtl/hex_display_scanner.sv
// Time-multiplexed scanner for a common-anode 7-segment display: byte-writable value register,
// frame-synchronous shadow copy, per-digit prescaler and optional leading-zero blanking.
module hex_display_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [31:0]           wr_data_i,
  input  logic [3:0]            wr_strb_i,
  input  logic                  en_i,
  input  logic                  blank_lz_i,
  output logic [31:0]           value_o,
  output logic [3:0]            nibble_o,
  output logic [NUM_DIGITS-1:0] digit_en_n_o,
  output logic                  blank_o,
  output logic                  frame_o
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [31:0]   value_reg;
  logic [31:0]   value_next;
  logic [31:0]   wr_mask;
  logic [DW-1:0] shadow_reg;
  logic [PW-1:0] presc_reg;
  logic [IW-1:0] idx_reg;
  logic          en_reg;
  logic          blz_reg;
  logic          frame_reg;

  logic run;
  logic tick;
  logic wrap;
  logic load;

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lead;

  genvar gi;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_mask[8*gi +: 8] = {8{wr_en_i & wr_strb_i[gi]}};
    end
  endgenerate

  assign value_next = (value_reg & ~wr_mask) | (wr_data_i & wr_mask);

  // Counting only starts once the enable has been seen for a full cycle, so
  // the first slot after (re)enable is as long as every other slot.
  assign run  = en_i & en_reg;
  assign tick = run & (presc_reg == PRESC_LAST);
  assign wrap = tick & (idx_reg == IDX_LAST);
  assign load = ~run | wrap;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_reg  <= '0;
      shadow_reg <= '0;
      presc_reg  <= '0;
      idx_reg    <= '0;
      en_reg     <= 1'b0;
      blz_reg    <= 1'b0;
      frame_reg  <= 1'b0;
    end else begin
      value_reg <= value_next;
      en_reg    <= en_i;
      blz_reg   <= blank_lz_i;
      frame_reg <= wrap;
      // Shadow samples the pre-write value so a write on a load edge shows next frame.
      if (load) begin
        shadow_reg <= value_reg[DW-1:0];
      end
      if (!run) begin
        presc_reg <= '0;
        idx_reg   <= '0;
      end else if (tick) begin
        presc_reg <= '0;
        idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

  // lead[i]: nibbles i..top are all zero; digit 0 always stays lit.
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
      assign nib[gi] = shadow_reg[4*gi +: 4];
      if (gi == 0) begin : g_first
        assign lead[gi] = 1'b0;
      end else if (gi == NUM_DIGITS - 1) begin : g_top
        assign lead[gi] = (nib[gi] == 4'd0);
      end else begin : g_mid
        assign lead[gi] = (nib[gi] == 4'd0) & lead[gi+1];
      end
      assign digit_en_n_o[gi] = blank_o | (idx_reg != IW'(gi));
    end
  endgenerate

  assign value_o  = value_reg;
  assign nibble_o = nib[idx_reg];
  assign blank_o  = ~en_reg | (blz_reg & lead[idx_reg]);
  assign frame_o  = frame_reg;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner (NUM_DIGITS=8, SCAN_DIV=4): directed tables and sequences
// plus random traffic against a time-based reference model.
module tb_hex_display_scanner;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        en;
  logic        blz;
  logic [31:0] value_o;
  logic [3:0]  nibble_o;
  logic [7:0]  digit_en_n;
  logic        blank_o;
  logic        frame_o;

  int tests = 0;
  int fails = 0;

  hex_display_scanner #(.NUM_DIGITS(8), .SCAN_DIV(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_en_i      (wr_en),
    .wr_data_i    (wr_data),
    .wr_strb_i    (wr_strb),
    .en_i         (en),
    .blank_lz_i   (blz),
    .value_o      (value_o),
    .nibble_o     (nibble_o),
    .digit_en_n_o (digit_en_n),
    .blank_o      (blank_o),
    .frame_o      (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: m_cyc counts enabled cycles since the scan (re)started,
  // the digit shown is (m_cyc / SCAN_DIV) mod 8, a frame starts every 32.
  logic [31:0] m_value;
  logic [31:0] m_shadow;
  bit          m_en;
  bit          m_blz;
  bit          m_frame;
  int          m_cyc;

  task automatic model_reset();
    m_value = 0; m_shadow = 0; m_en = 0; m_blz = 0; m_frame = 0; m_cyc = 0;
  endtask

  task automatic model_step();
    logic [31:0] pre;
    logic [31:0] mask;
    pre  = m_value;
    mask = 0;
    for (int k = 0; k < 4; k++) if (wr_strb[k]) mask = mask | (32'hFF << (8 * k));
    if (wr_en) m_value = (m_value & ~mask) | (wr_data & mask);
    m_frame = 0;
    if (!en) begin
      m_en = 0; m_cyc = 0; m_shadow = pre;
    end else if (!m_en) begin
      m_en = 1; m_cyc = 0; m_shadow = pre;
    end else begin
      m_cyc++;
      if (m_cyc % 32 == 0) begin
        m_shadow = pre; m_frame = 1;
      end
    end
    m_blz = blz;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    int          mi;
    bit          lead;
    bit          eblank;
    logic [7:0]  eden;
    logic [31:0] enib;
    mi     = m_en ? (m_cyc / 4) % 8 : 0;
    enib   = (m_shadow >> (4 * mi)) & 32'hF;
    lead   = (mi != 0) && ((m_shadow >> (4 * mi)) == 0);
    eblank = !m_en || (m_blz && lead);
    eden   = eblank ? 8'hFF : ~(8'h01 << mi);
    chk("model_value", value_o, m_value);
    chk("model_nibble", {28'h0, nibble_o}, enib);
    chk("model_blank", {31'h0, blank_o}, {31'h0, eblank});
    chk("model_digit_en", {24'h0, digit_en_n}, {24'h0, eden});
    chk("model_frame", {31'h0, frame_o}, {31'h0, m_frame});
  endtask

  task automatic tick_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic write(input logic [31:0] d);
    wr_en = 1; wr_data = d; wr_strb = 4'hF;
    tick_check();
    wr_en = 0;
  endtask

  task automatic wait_frame(input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (frame_o) seen = 1;
      else tick_check();
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: frame_o not seen within 100 cycles", name);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_value"}, value_o, 32'h0);
    chk({name, "_digit_en"}, {24'h0, digit_en_n}, 32'hFF);
    chk({name, "_blank"}, {31'h0, blank_o}, 32'h1);
    chk({name, "_frame"}, {31'h0, frame_o}, 32'h0);
    chk({name, "_nibble"}, {28'h0, nibble_o}, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } wvec_t;

  wvec_t      wv [7];
  logic [3:0] scan_exp [8];
  logic [7:0] e8;

  initial begin
    wv[0] = '{1'b1, 32'hFFFFFFFF, 4'b0010, 32'h0000FF00};
    wv[1] = '{1'b1, 32'hFFFFFFFF, 4'b0000, 32'h0000FF00};
    wv[2] = '{1'b1, 32'h12345678, 4'b0001, 32'h0000FF78};
    wv[3] = '{1'b1, 32'hAABBCCDD, 4'b1100, 32'hAABBFF78};
    wv[4] = '{1'b0, 32'h00000000, 4'b1111, 32'hAABBFF78};
    wv[5] = '{1'b1, 32'h00C30000, 4'b0100, 32'hAAC3FF78};
    wv[6] = '{1'b1, 32'h00000000, 4'b1111, 32'h00000000};
    scan_exp[0] = 4'hD; scan_exp[1] = 4'hC; scan_exp[2] = 4'hB; scan_exp[3] = 4'hA;
    scan_exp[4] = 4'h4; scan_exp[5] = 4'h3; scan_exp[6] = 4'h2; scan_exp[7] = 4'h1;

    rst_n = 0; wr_en = 0; wr_data = 0; wr_strb = 0; en = 0; blz = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1;

    // Byte-strobe table, scanning disabled
    for (int i = 0; i < 7; i++) begin
      wr_en = wv[i].we; wr_data = wv[i].data; wr_strb = wv[i].strb;
      tick_check();
      chk("wr_table", value_o, wv[i].exp);
      $display("[TB] write we=%0b data=%h strb=%b -> value_o=%h", wv[i].we, wv[i].data, wv[i].strb, value_o);
    end
    wr_en = 0;

    // Basic scan
    en = 1; blz = 0;
    write(32'h1234ABCD);
    wait_frame("scan_frame");
    for (int j = 0; j < 32; j++) begin
      e8 = ~(8'h01 << (j / 4));
      chk("scan_nibble", {28'h0, nibble_o}, {28'h0, scan_exp[j / 4]});
      chk("scan_digit_en", {24'h0, digit_en_n}, {24'h0, e8});
      chk("scan_frame_pulse", {31'h0, frame_o}, (j == 0) ? 32'h1 : 32'h0);
      tick_check();
    end
    chk("frame_period", {31'h0, frame_o}, 32'h1);

    // Write mid-frame must not tear the current frame
    repeat (12) tick_check();
    write(32'h11111111);
    for (int j = 13; j < 32; j++) begin
      chk("tear_old_nibble", {28'h0, nibble_o}, {28'h0, scan_exp[j / 4]});
      tick_check();
    end
    chk("tear_frame", {31'h0, frame_o}, 32'h1);
    chk("tear_new_nibble", {28'h0, nibble_o}, 32'h1);

    // Write landing exactly on the wrap edge shows one frame late
    repeat (31) tick_check();
    write(32'h5A5A5A5A);
    for (int j = 0; j < 32; j++) begin
      chk("wrap_write_old", {28'h0, nibble_o}, 32'h1);
      tick_check();
    end
    chk("wrap_write_new", {28'h0, nibble_o}, 32'hA);

    // Leading-zero blanking
    blz = 1;
    write(32'h00000050);
    wait_frame("lz_frame");
    for (int j = 0; j < 32; j++) begin
      e8 = (j / 4 >= 2) ? 8'hFF : ~(8'h01 << (j / 4));
      chk("lz_blank", {31'h0, blank_o}, (j / 4 >= 2) ? 32'h1 : 32'h0);
      chk("lz_digit_en", {24'h0, digit_en_n}, {24'h0, e8});
      if (j / 4 < 2) chk("lz_nibble", {28'h0, nibble_o}, (j / 4 == 0) ? 32'h0 : 32'h5);
      tick_check();
    end
    write(32'h00000000);
    wait_frame("lz0_frame");
    for (int j = 0; j < 32; j++) begin
      e8 = (j / 4 != 0) ? 8'hFF : 8'hFE;
      chk("lz0_digit_en", {24'h0, digit_en_n}, {24'h0, e8});
      if (j / 4 == 0) chk("lz0_nibble", {28'h0, nibble_o}, 32'h0);
      tick_check();
    end

    // Disable during slot 5, then re-enable
    blz = 0;
    write(32'h87654321);
    wait_frame("dis_frame");
    repeat (20) tick_check();
    en = 0;
    tick_check();
    chk("dis_blank", {31'h0, blank_o}, 32'h1);
    chk("dis_digit_en", {24'h0, digit_en_n}, 32'hFF);
    chk("dis_frame", {31'h0, frame_o}, 32'h0);
    chk("dis_nibble", {28'h0, nibble_o}, 32'h1);
    write(32'h0000000E);
    repeat (2) tick_check();
    en = 1;
    tick_check();
    for (int r = 0; r < 4; r++) begin
      chk("reen_digit_en", {24'h0, digit_en_n}, 32'hFE);
      chk("reen_nibble", {28'h0, nibble_o}, 32'hE);
      chk("reen_blank", {31'h0, blank_o}, 32'h0);
      tick_check();
    end
    chk("reen_slot1", {24'h0, digit_en_n}, 32'hFD);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> $urandom_range(0, 31));
      wr_strb = 4'($urandom_range(0, 15));
      en      = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 49) == 0) blz = ~blz;
      tick_check();
    end
    wr_en = 0;

    // Asynchronous reset mid-scan
    en = 1;
    write(32'hCAFE0123);
    repeat (13) tick_check();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk_reset_outputs("async_reset");
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("held_reset");
    rst_n = 1;
    repeat (40) tick_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
